// File: rtl/tbird_lights_seq.sv
// tbird_lights_seq: parametrised turn-signal / hazard lamp sequencer.
// A free-running prescaler produces a step tick every DIV clocks; the
// sequencer state only advances on ticks. Lamp outputs are decoded from
// the state register alone (Moore), so inputs never reach the lamps
// combinationally.
module tbird_lights_seq #(
  parameter int LAMPS = 3,  // lamps per side, >= 2, bit 0 innermost
  parameter int DIV   = 1,  // clocks per sequence step, >= 1
  parameter int CUMUL = 0   // 0 = one-hot walk, 1 = thermometer fill
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  output logic [LAMPS-1:0] l,
  output logic [LAMPS-1:0] r,
  output logic             active
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(LAMPS + 1);

  // Which side is sequencing; the position within the sequence lives in
  // step (1..LAMPS) so the lamp count can be a parameter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } mode_t;

  mode_t         mode, mode_nxt;
  logic [SW-1:0] step, step_nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [LAMPS-1:0] pattern;

  assign tick = (cnt == CW'(DIV - 1));

  // State and prescaler registers; reset dominates tick and all requests.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values, independent of statement order.
    if (reset) begin
      mode <= IDLE;
      step <= '0;
      cnt  <= '0;
    end else begin
      cnt  <= tick ? '0 : cnt + CW'(1);
      mode <= mode_nxt;
      step <= step_nxt;
    end
  end

  // Next-state on tick (hold otherwise) and Moore lamp decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave a signal unassigned (latch).
    mode_nxt = mode;
    step_nxt = step;
    l        = '0;
    r        = '0;
    active   = (mode != IDLE);
    pattern  = '0;

    if (tick) begin
      unique case (mode)
        IDLE: begin
          if (hazard) begin
            mode_nxt = HAZ;
          end else if (left && !right) begin
            mode_nxt = LEFT;
            step_nxt = SW'(1);
          end else if (right && !left) begin
            mode_nxt = RIGHT;
            step_nxt = SW'(1);
          end
        end
        LEFT, RIGHT: begin
          // Turn requests are ignored mid-sequence; only hazard preempts.
          if (hazard) begin
            mode_nxt = HAZ;
          end else if (step == SW'(LAMPS)) begin
            mode_nxt = IDLE;
          end else begin
            step_nxt = step + SW'(1);
          end
        end
        // One dark step after every flash; a held hazard re-enters next tick.
        HAZ:     mode_nxt = IDLE;
        default: mode_nxt = IDLE;
      endcase
    end

    for (int i = 0; i < LAMPS; i++) begin
      pattern[i] = (CUMUL != 0) ? (i < int'(step)) : (i == int'(step) - 1);
    end

    unique case (mode)
      LEFT:    l = pattern;
      RIGHT:   r = pattern;
      HAZ: begin
        l = '1;
        r = '1;
      end
      default: ;
    endcase
  end

endmodule
